// File: rtl/cu_pkg.sv
// Shared types, sizing constants and helpers for the compute-unit read/write data paths.
package cu_pkg;

  localparam int unsigned DATA_SIZE_READ = 128;
  localparam int unsigned ARRAY_SIZE     = 4;
  localparam int unsigned CU_ID_W        = 8;

  localparam int unsigned ELEMS      = DATA_SIZE_READ / ARRAY_SIZE;
  localparam int unsigned IDX_W      = (ELEMS > 1) ? $clog2(ELEMS) : 1;
  localparam int unsigned CNT_W      = $clog2(ELEMS + 1);
  localparam int unsigned ELEM_W     = ARRAY_SIZE * 8;
  localparam int unsigned LINE_W     = DATA_SIZE_READ * 8;
  localparam int unsigned SIZE_SHIFT = $clog2(ARRAY_SIZE);

  typedef logic [CU_ID_W-1:0] cu_id_t;

  // Line data is MSB-first: data[0:7] is the first byte in memory.
  typedef struct packed {
    logic              valid;
    cu_id_t            cu_id;
    logic [0:LINE_W-1] data;
  } DataRead;

  typedef enum logic {
    StIdle,
    StUnpack
  } unpack_state_t;

  // First byte in memory becomes the least significant byte.
  function automatic logic [ELEM_W-1:0] swap_endianness_elem(input logic [0:ELEM_W-1] elem);
    logic [ELEM_W-1:0] swapped;
    swapped = '0;
    for (int b = 0; b < int'(ARRAY_SIZE); b++) begin
      swapped[b*8 +: 8] = elem[b*8 +: 8];
    end
    return swapped;
  endfunction

  // Illegal sizes (not a power of two, or larger than a line) clamp to a full line.
  function automatic logic [CNT_W-1:0] elem_count_from_size(input logic [11:0] size);
    logic [11:0] shifted;
    shifted = size >> SIZE_SHIFT;
    if (size == '0) begin
      return '0;
    end
    if (((size & (size - 12'd1)) != '0) || (size > 12'(DATA_SIZE_READ))) begin
      return CNT_W'(ELEMS);
    end
    if (shifted == '0) begin
      return CNT_W'(1);
    end
    return CNT_W'(shifted);
  endfunction

endpackage

// File: rtl/cu_elem_select.sv
// Combinational element mux plus byte swap: maps (line, idx) to a host-order element.
module cu_elem_select
  import cu_pkg::*;
(
  input  logic [0:LINE_W-1] line_i,
  input  logic [IDX_W-1:0]  idx_i,
  output logic [ELEM_W-1:0] elem_o
);

  logic [0:ELEM_W-1] raw;

  always_comb begin
    raw = '0;
    for (int k = 0; k < int'(ELEMS); k++) begin
      if (idx_i == IDX_W'(k)) begin
        raw = line_i[k*ELEM_W +: ELEM_W];
      end
    end
    elem_o = swap_endianness_elem(raw);
  end

endmodule

// File: rtl/cu_read_data_unpacker.sv
// Splits a returned read line into byte-swapped elements streamed one per cycle.
module cu_read_data_unpacker
  import cu_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  DataRead           read_data_in,
  input  logic [11:0]       read_size_in,
  output logic              read_data_in_ready,
  output logic              elem_out_valid,
  output cu_id_t            elem_out_cu_id,
  output logic [IDX_W-1:0]  elem_out_index,
  output logic [ELEM_W-1:0] elem_out_data,
  output logic              elem_out_last,
  input  logic              elem_out_ready,
  output logic [31:0]       elem_count_out
);

  unpack_state_t     state_q, state_d;
  logic [0:LINE_W-1] line_q, line_d;
  cu_id_t            cu_id_q, cu_id_d;
  logic [CNT_W-1:0]  n_q, n_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [31:0]       count_q, count_d;

  logic [CNT_W-1:0]  n_in;
  logic              is_last;
  logic              load;

  always_comb begin
    n_in               = elem_count_from_size(read_size_in);
    is_last            = (state_q == StUnpack) && (CNT_W'(idx_q) == (n_q - CNT_W'(1)));
    state_d            = state_q;
    line_d             = line_q;
    cu_id_d            = cu_id_q;
    n_d                = n_q;
    idx_d              = idx_q;
    count_d            = count_q;
    read_data_in_ready = 1'b0;
    load               = 1'b0;

    case (state_q)
      StIdle: begin
        read_data_in_ready = 1'b1;
        if (read_data_in.valid && (n_in != '0)) begin
          load    = 1'b1;
          state_d = StUnpack;
        end
      end
      StUnpack: begin
        if (elem_out_ready) begin
          count_d = count_q + 32'd1;
          if (!is_last) begin
            idx_d = idx_q + IDX_W'(1);
          end else begin
            // Accept the next line in the last-element cycle so lines chain without a bubble.
            read_data_in_ready = 1'b1;
            if (read_data_in.valid && (n_in != '0)) begin
              load = 1'b1;
            end else begin
              state_d = StIdle;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      line_d  = read_data_in.data;
      cu_id_d = read_data_in.cu_id;
      n_d     = n_in;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      line_q  <= '0;
      cu_id_q <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      cu_id_q <= cu_id_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  cu_elem_select u_elem_select (
    .line_i (line_q),
    .idx_i  (idx_q),
    .elem_o (elem_out_data)
  );

  assign elem_out_valid = (state_q == StUnpack);
  assign elem_out_last  = is_last;
  assign elem_out_index = idx_q;
  assign elem_out_cu_id = cu_id_q;
  assign elem_count_out = count_q;

endmodule

// File: tb/tb_cu_read_data_unpacker.sv
// Directed bench for cu_read_data_unpacker: table of line sizes plus multi-cycle corner cases.
module tb_cu_read_data_unpacker;
  import cu_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  DataRead           read_data_in;
  logic [11:0]       read_size_in;
  logic              read_data_in_ready;
  logic              elem_out_valid;
  cu_id_t            elem_out_cu_id;
  logic [IDX_W-1:0]  elem_out_index;
  logic [ELEM_W-1:0] elem_out_data;
  logic              elem_out_last;
  logic              elem_out_ready;
  logic [31:0]       elem_count_out;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_count = '0;

  typedef struct {
    logic [11:0] size;
    logic [7:0]  cu;
    logic [7:0]  base;
    int          exp_n;
  } vec_t;

  vec_t tbl[10];

  cu_read_data_unpacker dut (
    .clock              (clock),
    .reset              (reset),
    .read_data_in       (read_data_in),
    .read_size_in       (read_size_in),
    .read_data_in_ready (read_data_in_ready),
    .elem_out_valid     (elem_out_valid),
    .elem_out_cu_id     (elem_out_cu_id),
    .elem_out_index     (elem_out_index),
    .elem_out_data      (elem_out_data),
    .elem_out_last      (elem_out_last),
    .elem_out_ready     (elem_out_ready),
    .elem_count_out     (elem_count_out)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required $finish)");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Line byte i holds base+i, so element k holds bytes base+4k .. base+4k+3.
  function automatic logic [31:0] exp_elem(input logic [7:0] base, input int k);
    logic [7:0] b0;
    b0 = base + 8'(4 * k);
    return {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
  endfunction

  task automatic set_line(input logic [11:0] size, input logic [7:0] cu, input logic [7:0] base);
    read_data_in.valid = 1'b1;
    read_data_in.cu_id = cu;
    for (int i = 0; i < int'(DATA_SIZE_READ); i++) begin
      read_data_in.data[i*8 +: 8] = base + 8'(i);
    end
    read_size_in = size;
  endtask

  // Called at a negedge with the DUT idle and elem_out_ready = 1.
  task automatic run_line(input logic [11:0] size, input logic [7:0] cu, input logic [7:0] base,
                          input int exp_n);
    set_line(size, cu, base);
    #1;
    check("in_ready_idle", 64'(read_data_in_ready), 64'd1);
    @(negedge clock);
    read_data_in.valid = 1'b0;
    for (int k = 0; k < exp_n; k++) begin
      #1;
      check("valid", 64'(elem_out_valid), 64'd1);
      check("index", 64'(elem_out_index), 64'(k));
      check("data", 64'(elem_out_data), 64'(exp_elem(base, k)));
      check("last", 64'(elem_out_last), 64'(k == exp_n - 1));
      check("cu_id", 64'(elem_out_cu_id), 64'(cu));
      check("in_ready_stream", 64'(read_data_in_ready), 64'(k == exp_n - 1));
      @(negedge clock);
    end
    exp_count = exp_count + 32'(exp_n);
    #1;
    check("valid_after", 64'(elem_out_valid), 64'd0);
    check("in_ready_after", 64'(read_data_in_ready), 64'd1);
    check("count", 64'(elem_count_out), 64'(exp_count));
  endtask

  initial begin
    tbl[0] = '{12'd128, 8'd1,  8'h00, 32};
    tbl[1] = '{12'd8,   8'd2,  8'h00, 2};
    tbl[2] = '{12'd2,   8'd3,  8'h10, 1};
    tbl[3] = '{12'd0,   8'd4,  8'h00, 0};
    tbl[4] = '{12'd64,  8'd5,  8'h33, 16};
    tbl[5] = '{12'd4,   8'd6,  8'hF0, 1};
    tbl[6] = '{12'd6,   8'd7,  8'h00, 32};
    tbl[7] = '{12'd256, 8'd8,  8'h00, 32};
    tbl[8] = '{12'd1,   8'd9,  8'h00, 1};
    tbl[9] = '{12'd32,  8'd10, 8'h80, 8};

    reset          = 1'b1;
    read_data_in   = '0;
    read_size_in   = '0;
    elem_out_ready = 1'b1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_valid", 64'(elem_out_valid), 64'd0);
    check("rst_last", 64'(elem_out_last), 64'd0);
    check("rst_index", 64'(elem_out_index), 64'd0);
    check("rst_data", 64'(elem_out_data), 64'd0);
    check("rst_cu_id", 64'(elem_out_cu_id), 64'd0);
    check("rst_count", 64'(elem_count_out), 64'd0);
    check("rst_in_ready", 64'(read_data_in_ready), 64'd1);
    @(negedge clock);
    reset = 1'b0;

    // Full line of bytes 0x00..0x7F: element 0 must be 0x03020100.
    set_line(12'd128, 8'd1, 8'h00);
    @(negedge clock);
    read_data_in.valid = 1'b0;
    #1;
    check("full_idx0_data", 64'(elem_out_data), 64'h03020100);
    repeat (31) @(negedge clock);
    #1;
    check("full_idx31_data", 64'(elem_out_data), 64'h7F7E7D7C);
    check("full_idx31_last", 64'(elem_out_last), 64'd1);
    @(negedge clock);
    exp_count = exp_count + 32'd32;
    #1;
    check("full_count", 64'(elem_count_out), 64'd32);
    @(negedge clock);

    for (int v = 0; v < 10; v++) begin
      run_line(tbl[v].size, tbl[v].cu, tbl[v].base, tbl[v].exp_n);
      @(negedge clock);
    end

    // Backpressure: consumer stalls 5 cycles while idx 3 is presented.
    begin
      int exp_idx;
      exp_idx = 0;
      set_line(12'd32, 8'd3, 8'h40);
      @(negedge clock);
      read_data_in.valid = 1'b0;
      for (int cyc = 0; cyc < 13; cyc++) begin
        elem_out_ready = !(cyc >= 3 && cyc < 8);
        #1;
        check("bp_valid", 64'(elem_out_valid), 64'd1);
        check("bp_index", 64'(elem_out_index), 64'(exp_idx));
        check("bp_data", 64'(elem_out_data), 64'(exp_elem(8'h40, exp_idx)));
        check("bp_cu_id", 64'(elem_out_cu_id), 64'd3);
        if (elem_out_ready) exp_idx++;
        @(negedge clock);
      end
      elem_out_ready = 1'b1;
      exp_count = exp_count + 32'd8;
      #1;
      check("bp_valid_after", 64'(elem_out_valid), 64'd0);
      check("bp_count", 64'(elem_count_out), 64'(exp_count));
      @(negedge clock);
    end

    // Back-to-back: A (16 B, cu 2) then B (8 B, cu 5) with no idle cycle between.
    set_line(12'd16, 8'd2, 8'h00);
    @(negedge clock);
    set_line(12'd8, 8'd5, 8'hA0);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) read_data_in.valid = 1'b0;
      #1;
      check("b2b_valid", 64'(elem_out_valid), 64'd1);
      check("b2b_index", 64'(elem_out_index), 64'((i < 4) ? i : i - 4));
      check("b2b_cu_id", 64'(elem_out_cu_id), 64'((i < 4) ? 2 : 5));
      check("b2b_data", 64'(elem_out_data),
            64'((i < 4) ? exp_elem(8'h00, i) : exp_elem(8'hA0, i - 4)));
      check("b2b_last", 64'(elem_out_last), 64'(i == 3 || i == 5));
      check("b2b_in_ready", 64'(read_data_in_ready), 64'(i == 3 || i == 5));
      @(negedge clock);
    end
    exp_count = exp_count + 32'd6;
    #1;
    check("b2b_valid_after", 64'(elem_out_valid), 64'd0);
    check("b2b_count", 64'(elem_count_out), 64'(exp_count));
    @(negedge clock);

    // Reset after 10 of 32 elements; the partial line is dropped.
    set_line(12'd128, 8'd7, 8'h10);
    @(negedge clock);
    read_data_in.valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("rstmid_index", 64'(elem_out_index), 64'(k));
      @(negedge clock);
    end
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("rstmid_valid", 64'(elem_out_valid), 64'd0);
    check("rstmid_count", 64'(elem_count_out), 64'd0);
    check("rstmid_in_ready", 64'(read_data_in_ready), 64'd1);
    check("rstmid_index0", 64'(elem_out_index), 64'd0);
    check("rstmid_data0", 64'(elem_out_data), 64'd0);
    check("rstmid_cu_id0", 64'(elem_out_cu_id), 64'd0);
    reset     = 1'b0;
    exp_count = '0;
    @(negedge clock);
    run_line(12'd8, 8'd9, 8'h20, 2);
    @(negedge clock);

    // Counter wrap from 0xFFFFFFFF.
    force dut.count_q = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.count_q;
    #1;
    check("wrap_preset", 64'(elem_count_out), 64'hFFFF_FFFF);
    exp_count = 32'hFFFF_FFFF;
    @(negedge clock);
    run_line(12'd4, 8'd1, 8'h55, 1);
    check("wrap_count", 64'(elem_count_out), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cu_read_data_unpacker.md
# cu_read_data_unpacker

Receive-side counterpart of the compute-unit read command path. Accepts one returned read line (`DataRead`: valid, cu_id, DATA_SIZE_READ bytes), plus the power-of-two request size the command path issued for it. Splits the line into ARRAY_SIZE-byte elements, byte-swaps each element to host order, and streams them one per cycle under a valid/ready handshake. Sits between the read response buffer and the compute-unit datapath.

## Interface
Parameters:
- DATA_SIZE_READ, 128: bytes per returned line.
- ARRAY_SIZE, 4: bytes per element; power of two, ≤ DATA_SIZE_READ.
- Derived constants:
  - ELEMS = DATA_SIZE_READ/ARRAY_SIZE.
  - IDX_W = max(1, $clog2(ELEMS)).

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- read_data_in  in  DataRead  line; `.valid` qualifies.
- read_size_in  in  12  issued request size in bytes: 0 or a power of two ≤ DATA_SIZE_READ.
- read_data_in_ready  out  1  line accepted on `read_data_in.valid && read_data_in_ready`.
- elem_out_valid  out  1  element present.
- elem_out_cu_id  out  cu_id_t  cu_id of the source line.
- elem_out_index  out  IDX_W  element offset within the line.
- elem_out_data  out  ARRAY_SIZE*8  byte-swapped element.
- elem_out_last  out  1  final element of the line.
- elem_out_ready  in  1  consumer accepts the element.
- elem_count_out  out  32  total elements emitted since reset; wraps.

## Operation
- Element count per line: n = read_size_in >> $clog2(ARRAY_SIZE).
  - If read_size_in is nonzero but smaller than ARRAY_SIZE, n = 1.
  - If read_size_in = 0, n = 0.
- Element k (0..n-1) is taken from `data[k*ARRAY_SIZE*8 +: ARRAY_SIZE*8]`, using the MSB-first [0:N-1] ordering, with bytes reversed. The first byte in memory becomes the least significant byte.
- FSM:
  - IDLE:
    - read_data_in_ready = 1.
    - On accept with n > 0: latch line, cu_id and n; set idx = 0; go to UNPACK.
    - On accept with n = 0: discard the line, stay in IDLE.
  - UNPACK:
    - elem_out_valid = 1; index = idx; last = (idx == n-1).
    - On handshake with last = 0: idx += 1.
    - On handshake with last = 1:
      - read_data_in_ready = 1 in that same cycle, giving zero-bubble chaining.
      - If a new line with n > 0 is accepted, latch it, set idx = 0, stay in UNPACK.
      - Otherwise go to IDLE.
    - read_data_in_ready = 0 at all other times in UNPACK.
- elem_count_out increments by 1 on every output handshake and wraps at 2^32.
- Illegal read_size_in values (not a power of two, or > DATA_SIZE_READ): n is clamped to ELEMS. No error flag.

## Timing
- Reset values:
  - FSM = IDLE.
  - read_data_in_ready = 1 (combinational from IDLE).
  - elem_out_valid = 0, elem_out_last = 0.
  - elem_out_index = 0, elem_out_data = 0, elem_out_cu_id = 0.
  - elem_count_out = 0.
- Latency: line accepted at edge N → element 0 valid in cycle N+1. All element outputs are registered or derived from registered state.
- Throughput: one element per cycle while elem_out_ready = 1.
  - A line of n elements occupies exactly n cycles.
  - Back-to-back lines have no idle cycle between them.
- Output stability: while elem_out_valid = 1 and elem_out_ready = 0, all elem_out_* hold stable, and valid must not drop.
- Input ready is combinational from FSM state and elem_out_ready. There is no combinational path from read_data_in to read_data_in_ready.
- Reset mid-UNPACK: the next cycle is IDLE with outputs at reset values. The partial line is dropped and not replayed.
- Reset has priority over every simultaneous handshake in the same cycle.

## Structure
- CU_PKG owns the shared types and helpers:
  - `DataRead`, cu_id_t.
  - A per-element byte-swap function, `swap_endianness_elem`, parameterised on ARRAY_SIZE and modelled on the existing swap helpers.
  - A function `elem_count_from_size(size)`, the inverse of cmd_size_calculate.
- The FSM state enum `unpack_state_t` (IDLE, UNPACK) also lives in CU_PKG.
- One sub-module is natural: `cu_elem_select`, a combinational mux plus byte-swap that maps (line, idx) to an element. It is reusable by the write-side packer tests.

## Test plan
- Single full line:
  - Stimulus: bytes 0x00..0x7F, size 128, ready held 1.
  - Response: 32 elements on consecutive cycles starting one cycle after accept.
    - idx0 data = 0x03020100.
    - idx31 data = 0x7F7E7D7C, last = 1.
  - elem_count_out = 32 afterwards.
- Partial sizes:
  - Size 8 → 2 elements (idx0, idx1 with last).
  - Size 2 → 1 element with last.
  - Size 0 → no output; read_data_in_ready stays 1.
- Backpressure:
  - Stimulus: ready = 0 for 5 cycles while idx = 3 is presented.
  - Response: idx3, data and cu_id hold, valid stays 1; streaming resumes with idx4; no element is lost or duplicated.
- Back-to-back:
  - Stimulus: line A (size 16, cu_id 2) immediately followed by line B (size 8, cu_id 5).
  - Response: 4+2 elements in 6 consecutive cycles; in_ready high only in A's last-element cycle; cu_id switches 2→5 at B's idx0.
- Reset mid-line:
  - Stimulus: assert reset after 10 of 32 elements.
  - Response: next cycle valid = 0, count = 0, in_ready = 1; a fresh line then streams from idx0.
- Counter wrap:
  - Stimulus: force elem_count_out to 0xFFFFFFFF, emit one element.
  - Response: elem_count_out reads 0.
